hyperbus_trans_arbiter: RTL and testbench

Round-robin arbiter that shares the single HyperBus PHY transaction channel between NumReq AXI-side requesters. It issues one transaction at a time to the read/write datapath splitters and counts response beats until completion. It exposes the granted requester index so response beats can be steered back.
- Sits between the per-port AXI front-ends and the PHY command path.
- Generates the transaction handshake consumed by the read splitter.

---
 rtl/hyperbus_arb_pkg.sv | 18 +
 rtl/hyperbus_rr_picker.sv | 18 +
 rtl/hyperbus_trans_arbiter.sv | 104 ++++++++++
 tb/tb_hyperbus_trans_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hyperbus_arb_pkg.sv
// hyperbus_arb_pkg: shared state encoding, request record and default configuration for the HyperBus transaction arbiter
package hyperbus_arb_pkg;
  localparam int DefNumReq = 2;
  localparam int DefAddrWidth = 32;
  localparam int DefBurstLength = 8;
  localparam int DefTimeoutCycles = 1024;
  typedef enum logic [1:0] {
    Idle = 2'd0,
    Issue = 2'd1,
    Busy = 2'd2
  } arb_state_t;
  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefBurstLength-1:0] len;
    logic [2:0] size;
    logic write;
  } trans_req_t;
endpackage

// File: rtl/hyperbus_rr_picker.sv
// hyperbus_rr_picker: combinational round-robin first-one search over req starting at ptr, wrapping modulo NumReq
module hyperbus_rr_picker #(
  parameter int NumReq = 2,
  parameter int IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  req,
  input  logic [IdWidth-1:0] ptr,
  output logic [IdWidth-1:0] gnt_idx,
  output logic               any_valid
);
  always_comb begin
    gnt_idx = '0;
    any_valid = |req;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NumReq]) gnt_idx = IdWidth'((int'(ptr) + i) % NumReq);
    end
  end
endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// hyperbus_trans_arbiter: round-robin single-transaction arbiter for the HyperBus PHY channel with beat accounting (watchdog via HYPERBUS_ARB_TIMEOUT_EN)
module hyperbus_trans_arbiter
  import hyperbus_arb_pkg::*;
#(
  parameter int NumReq = DefNumReq,
  parameter int AddrWidth = DefAddrWidth,
  parameter int BurstLength = DefBurstLength,
  parameter int TimeoutCycles = DefTimeoutCycles,
  parameter int IdWidth = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*BurstLength-1:0] req_len_i,
  input  logic [NumReq*3-1:0]           req_size_i,
  input  logic [NumReq-1:0]             req_write_i,
  output logic                          trans_valid_o,
  input  logic                          trans_ready_i,
  output logic [AddrWidth-1:0]          trans_addr_o,
  output logic [BurstLength-1:0]        trans_len_o,
  output logic [2:0]                    trans_size_o,
  output logic                          trans_write_o,
  output logic [IdWidth-1:0]            trans_id_o,
  output logic                          busy_o,
  input  logic                          beat_i,
  input  logic                          done_i,
  output logic                          error_o
);
  localparam int CntW = BurstLength + 1;
  arb_state_t state, state_n;
  logic [IdWidth-1:0] gnt, ptr;
  logic any, err_n, tmo, accept;
  logic [CntW-1:0] cnt, cnt_n, exp_q;
  hyperbus_rr_picker #(.NumReq(NumReq), .IdWidth(IdWidth)) u_picker (
    .req(req_valid_i),
    .ptr(ptr),
    .gnt_idx(gnt),
    .any_valid(any)
  );
  assign accept = state == Idle && any;
  assign req_ready_o = accept ? NumReq'(1) << gnt : '0;
  assign trans_valid_o = state == Issue;
  assign busy_o = state != Idle;
  always_comb begin
    cnt_n = cnt;
    err_n = error_o;
    state_n = state;
    if (state == Busy && beat_i) begin
      err_n = err_n | (cnt == exp_q);
      cnt_n = cnt == exp_q ? cnt : cnt + 1'b1;
    end
    if (state != Busy && (beat_i || done_i)) err_n = 1'b1;
    if (accept) state_n = Issue;
    if (state == Issue && trans_ready_i) state_n = Busy;
    if (state == Busy && done_i) begin
      state_n = Idle;
      err_n = err_n | (cnt_n != exp_q);
    end
    if (tmo) begin
      state_n = Idle;
      err_n = 1'b1;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= Idle;
      ptr <= '0;
      cnt <= '0;
      exp_q <= '0;
      error_o <= 1'b0;
      trans_addr_o <= '0;
      trans_len_o <= '0;
      trans_size_o <= '0;
      trans_write_o <= 1'b0;
      trans_id_o <= '0;
    end else begin
      state <= state_n;
      error_o <= err_n;
      cnt <= state == Issue ? '0 : cnt_n;
      if (accept) begin
        trans_addr_o <= req_addr_i[gnt*AddrWidth +: AddrWidth];
        trans_len_o <= req_len_i[gnt*BurstLength +: BurstLength];
        trans_size_o <= req_size_i[gnt*3 +: 3];
        trans_write_o <= req_write_i[gnt];
        trans_id_o <= gnt;
      end
      if (state == Issue && trans_ready_i) exp_q <= CntW'(trans_len_o) + 1'b1;
      if (state != Idle && state_n == Idle) ptr <= trans_id_o == IdWidth'(NumReq - 1) ? '0 : trans_id_o + 1'b1;
    end
  end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt;
  assign tmo = state != Idle && !beat_i && tmo_cnt == TmoW'(TimeoutCycles - 1);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_cnt <= '0;
    else tmo_cnt <= (state == Idle || state_n != state || beat_i) ? '0 : tmo_cnt + 1'b1;
  end
`else
  assign tmo = TimeoutCycles < 0;
`endif
endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// tb_hyperbus_trans_arbiter: directed self-checking bench for the HyperBus transaction arbiter
module tb_hyperbus_trans_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, req_write;
  logic [63:0] req_addr;
  logic [15:0] req_len;
  logic [5:0] req_size;
  logic trans_valid, trans_ready, trans_write, trans_id, busy, beat, done, error;
  logic [31:0] trans_addr;
  logic [7:0] trans_len;
  logic [2:0] trans_size;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  hyperbus_trans_arbiter #(
    .NumReq(2),
    .AddrWidth(32),
    .BurstLength(8),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i(req_addr),
    .req_len_i(req_len),
    .req_size_i(req_size),
    .req_write_i(req_write),
    .trans_valid_o(trans_valid),
    .trans_ready_i(trans_ready),
    .trans_addr_o(trans_addr),
    .trans_len_o(trans_len),
    .trans_size_o(trans_size),
    .trans_write_o(trans_write),
    .trans_id_o(trans_id),
    .busy_o(busy),
    .beat_i(beat),
    .done_i(done),
    .error_o(error)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    beat = 1'b0;
    done = 1'b0;
    #1;
    chk("rst_valid", trans_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", error, 0);
    chk("rst_id", trans_id, 0);
    chk("rst_addr", trans_addr, 0);
    step();
    rst = 1'b0;
  endtask
  task automatic txn(input logic [1:0] v, input logic id, input int nbeats, input logic exp_err);
    req_valid = v;
    #1;
    chk("grant", req_ready, id ? 2'b10 : 2'b01);
    step();
    chk("issue_valid", trans_valid, 1);
    chk("issue_id", trans_id, id);
    chk("issue_addr", trans_addr, id ? 32'h2000 : 32'h100);
    chk("issue_rdy0", req_ready, 0);
    step();
    chk("busy", busy, 1);
    beat = 1'b1;
    repeat (nbeats - 1) step();
    done = 1'b1;
    step();
    beat = 1'b0;
    done = 1'b0;
    req_valid = '0;
    #1;
    chk("done_busy", busy, 0);
    chk("done_err", error, exp_err);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    trans_ready = 1'b1;
    req_addr = {32'h2000, 32'h100};
    req_len = {8'd0, 8'd3};
    req_size = {3'd1, 3'd2};
    req_write = 2'b10;
    do_reset();
    req_valid = 2'b01;
    #1;
    chk("t1_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    chk("t1_valid", trans_valid, 1);
    chk("t1_id", trans_id, 0);
    chk("t1_addr", trans_addr, 32'h100);
    chk("t1_len", trans_len, 3);
    chk("t1_size", trans_size, 2);
    chk("t1_write", trans_write, 0);
    chk("t1_busy_issue", busy, 1);
    step();
    chk("t1_valid_off", trans_valid, 0);
    beat = 1'b1;
    repeat (4) step();
    beat = 1'b0;
    chk("t1_busy_beats", busy, 1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t1_idle", busy, 0);
    chk("t1_err", error, 0);
    txn(2'b01, 1'b0, 4, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) txn(2'b11, i[0], i[0] ? 1 : 4, 1'b0);
    trans_ready = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("stall_grant", req_ready, 2'b01);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", trans_valid, 1);
      chk("stall_addr", trans_addr, 32'h100);
      chk("stall_rdy", req_ready, 0);
      step();
    end
    trans_ready = 1'b1;
    #1;
    chk("stall_valid11", trans_valid, 1);
    step();
    chk("stall_accept", trans_valid, 0);
    chk("stall_busy", busy, 1);
    beat = 1'b1;
    repeat (4) step();
    beat = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    req_valid = '0;
    chk("stall_err", error, 0);
    req_len = {8'd0, 8'd1};
    txn(2'b01, 1'b0, 1, 1'b1);
    beat = 1'b1;
    step();
    beat = 1'b0;
    chk("idle_beat_err", error, 1);
    chk("idle_beat_busy", busy, 0);
    do_reset();
`ifdef HYPERBUS_ARB_TIMEOUT_EN
    req_valid = 2'b11;
    step();
    step();
    repeat (15) step();
    chk("tmo_early_err", error, 0);
    chk("tmo_early_busy", busy, 1);
    step();
    chk("tmo_err", error, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_next", req_ready, 2'b10);
    req_valid = '0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
